// File: rtl/arb_master_port_if.sv
// Bundle of the command, arbitration and beat signals of one arb_master_port.
// master: the port's view. slave: the view of local logic plus the arbiter.
interface arb_master_port_if #(
   parameter int LEN_W = 4,
   parameter int DEPTH = 4
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic             gnt;
   logic             req;
   logic             end_access;
   logic             beat;
   logic [LEN_W-1:0] beat_idx;
   logic             busy;
   logic [LVL_W-1:0] fifo_level;
   logic             proto_err;
   logic             to_err;

   modport master (
      input  cmd_valid, cmd_len, gnt,
      output cmd_ready, req, end_access, beat, beat_idx, busy, fifo_level,
             proto_err, to_err
   );

   modport slave (
      output cmd_valid, cmd_len, gnt,
      input  cmd_ready, req, end_access, beat, beat_idx, busy, fifo_level,
             proto_err, to_err
   );
endinterface

// File: rtl/arb_master_port.sv
// Requester-side endpoint of the 3-master weighted round-robin arbitration
// protocol. Queues burst commands, requests the bus, strobes beats for each
// granted tenure and pulses end_access with the last beat.
// Optional grant-wait timeout: define ARB_MASTER_TIMEOUT_EN.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | nothing in service; leaves as soon as the FIFO is non-empty
//  REQ     | req asserted for the head command, waiting for gnt
//  XFER    | own the bus, one beat per cycle until beat_idx == len_q
module arb_master_port #(
   parameter int LEN_W     = 4,
   parameter int DEPTH     = 4,
   parameter int TO_CYCLES = 64
) (
   input  logic                clk,
   input  logic                resetb,
   arb_master_port_if.master   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TO_CYCLES < 1) begin : g_bad_param
      $error("arb_master_port: DEPTH must be a power of 2 >= 2, TO_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, nxt_ptr;
   logic [LVL_W-1:0] level_q;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             proto_q, proto_d;
   logic             to_err_q, to_err_d;
   logic             push, pop, full, more, last_beat, timeout;

   assign full      = (level_q == LVL_W'(DEPTH));
   assign push      = bus.cmd_valid && !full;
   assign nxt_ptr   = rd_ptr_q + PTR_W'(1);
   assign more      = (level_q > LVL_W'(1));
   assign last_beat = (idx_q == len_q);

`ifdef ARB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYCLES) + 1;
   logic [CNT_W-1:0] wait_q;

   assign timeout = (state_q == ST_REQ) && !bus.gnt &&
                    (wait_q == CNT_W'(TO_CYCLES - 1));

   // Count ungranted REQ cycles; zero outside REQ so every REQ entry starts fresh.
   always_ff @(posedge clk) begin
      if (resetb) begin
         wait_q <= '0;
      end else if (state_q == ST_REQ && !bus.gnt && !timeout) begin
         wait_q <= wait_q + CNT_W'(1);
      end else begin
         wait_q <= '0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Command storage; contents need no reset because level/pointers gate use.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.cmd_len;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves level unchanged.
   always_ff @(posedge clk) begin
      if (resetb) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= nxt_ptr;
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // FSM state and tenure bookkeeping registers.
   always_ff @(posedge clk) begin
      if (resetb) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         idx_q    <= '0;
         proto_q  <= 1'b0;
         to_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         proto_q  <= proto_d;
         to_err_q <= to_err_d;
      end
   end

   // Next-state logic. The next length is taken from the entry behind the head
   // only when it was already queued; a command pushed during the pop cycle is
   // picked up from IDLE one cycle later.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      idx_d    = idx_q;
      proto_d  = proto_q;
      to_err_d = 1'b0;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (level_q != '0) begin
               state_d = ST_REQ;
               len_d   = mem[rd_ptr_q];
            end
         end
         ST_REQ: begin
            if (bus.gnt) begin
               state_d = ST_XFER;
               idx_d   = '0;
            end else if (timeout) begin
               to_err_d = 1'b1;
               pop      = 1'b1;
               if (more) begin
                  state_d = ST_REQ;
                  len_d   = mem[nxt_ptr];
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_XFER: begin
            if (last_beat) begin
               pop = 1'b1;
               if (more) begin
                  state_d = ST_REQ;
                  len_d   = mem[nxt_ptr];
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (!bus.gnt) begin
               proto_d = 1'b1;
               pop     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + LEN_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode registered state only.
   assign bus.cmd_ready  = !full;
   assign bus.req        = (state_q == ST_REQ) || ((state_q == ST_XFER) && more);
   assign bus.beat       = (state_q == ST_XFER);
   assign bus.beat_idx   = (state_q == ST_XFER) ? idx_q : '0;
   assign bus.end_access = (state_q == ST_XFER) && last_beat;
   assign bus.busy       = (state_q != ST_IDLE) || (level_q != '0);
   assign bus.fifo_level = level_q;
   assign bus.proto_err  = proto_q;
   assign bus.to_err     = to_err_q;
endmodule

// File: tb/tb_arb_master_port.sv
// Bench for arb_master_port: directed timing scenarios followed by a
// randomized run against a queue-based transaction model and a simple
// registered-grant arbiter.
module tb_arb_master_port;
   localparam int LEN_W = 4;
   localparam int DEPTH = 4;
   localparam int TO_CYC = 8;

   logic clk = 1'b0;
   logic resetb = 1'b1;
   int   checks = 0;
   int   failures = 0;

   arb_master_port_if #(.LEN_W(LEN_W), .DEPTH(DEPTH)) bus ();

   arb_master_port #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TO_CYCLES(TO_CYC)) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      resetb = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.gnt = 1'b0;
      step();
      step();
      resetb = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int model_level, exp_idx, wait_n, bursts;
      logic [LEN_W-1:0] exp_q[$];
      logic [LEN_W-1:0] len;
      logic nxt_gnt, pushv, acc, last;

      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.gnt       = 1'b0;
      do_reset();

      // reset state
      chk("rst_req",   bus.req, 0);
      chk("rst_beat",  bus.beat, 0);
      chk("rst_end",   bus.end_access, 0);
      chk("rst_idx",   bus.beat_idx, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_proto", bus.proto_err, 0);
      chk("rst_toerr", bus.to_err, 0);
      chk("rst_ready", bus.cmd_ready, 1);

      // single 4-beat burst: accept at A, req at A+2, grant at A+3, beats A+4..A+7
      step();
      bus.cmd_valid = 1'b1; bus.cmd_len = 4'd3;
      step();
      bus.cmd_valid = 1'b0;
      chk("t1_req_a1", bus.req, 0);
      chk("t1_level_a1", bus.fifo_level, 1);
      step();
      chk("t1_req_a2", bus.req, 1);
      chk("t1_beat_a2", bus.beat, 0);
      step();
      bus.gnt = 1'b1;
      chk("t1_beat_g", bus.beat, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_beat", bus.beat, 1);
         chk("t1_idx", bus.beat_idx, i);
         chk("t1_end", bus.end_access, (i == 3));
         chk("t1_level_x", bus.fifo_level, 1);
      end
      step();
      bus.gnt = 1'b0;
      chk("t1_beat_after", bus.beat, 0);
      chk("t1_end_after", bus.end_access, 0);
      chk("t1_level_after", bus.fifo_level, 0);
      chk("t1_busy_after", bus.busy, 0);

      // back-to-back lens 0 and 2 under a continuous grant
      bus.cmd_valid = 1'b1; bus.cmd_len = 4'd0;
      step();
      bus.cmd_len = 4'd2;
      step();
      bus.cmd_valid = 1'b0; bus.gnt = 1'b1;
      chk("t2_req_b2", bus.req, 1);
      chk("t2_level_b2", bus.fifo_level, 2);
      step();
      chk("t2_beat_b3", bus.beat, 1);
      chk("t2_end_b3", bus.end_access, 1);
      chk("t2_req_b3", bus.req, 1);
      step();
      chk("t2_beat_b4", bus.beat, 0);
      chk("t2_req_b4", bus.req, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_beat", bus.beat, 1);
         chk("t2_idx", bus.beat_idx, i);
         chk("t2_end", bus.end_access, (i == 2));
         chk("t2_req", bus.req, 0);
      end
      step();
      bus.gnt = 1'b0;
      chk("t2_level_end", bus.fifo_level, 0);
      chk("t2_busy_end", bus.busy, 0);

      // fill the FIFO, offer a fifth command, then release one entry
      for (int i = 0; i < 4; i++) begin
         bus.cmd_valid = 1'b1; bus.cmd_len = 4'd0;
         chk("t3_ready_fill", bus.cmd_ready, 1);
         step();
      end
      bus.cmd_len = 4'd5;
      chk("t3_ready_full", bus.cmd_ready, 0);
      chk("t3_level_full", bus.fifo_level, 4);
      step();
      bus.cmd_valid = 1'b0; bus.gnt = 1'b1;
      chk("t3_level_fifth", bus.fifo_level, 4);
      chk("t3_ready_fifth", bus.cmd_ready, 0);
      step();
      chk("t3_end_first", bus.end_access, 1);
      chk("t3_ready_popcycle", bus.cmd_ready, 0);
      step();
      chk("t3_level_pop", bus.fifo_level, 3);
      chk("t3_ready_pop", bus.cmd_ready, 1);
      n = 0;
      for (int i = 0; i < 40 && bus.busy; i++) begin
         if (bus.end_access) begin
            n++;
            chk("t3_drain_idx", bus.beat_idx, 0);
         end
         step();
      end
      bus.gnt = 1'b0;
      chk("t3_drain_busy", bus.busy, 0);
      chk("t3_drain_bursts", n, 3);

      // grant dropped at beat 1 of a 4-beat burst
      bus.cmd_valid = 1'b1; bus.cmd_len = 4'd3;
      step();
      bus.cmd_valid = 1'b0;
      step();
      bus.gnt = 1'b1;
      chk("t4_req", bus.req, 1);
      step();
      chk("t4_idx0", bus.beat_idx, 0);
      chk("t4_end0", bus.end_access, 0);
      step();
      chk("t4_idx1", bus.beat_idx, 1);
      chk("t4_end1", bus.end_access, 0);
      bus.gnt = 1'b0;
      step();
      chk("t4_proto", bus.proto_err, 1);
      chk("t4_beat", bus.beat, 0);
      chk("t4_end", bus.end_access, 0);
      chk("t4_req_low", bus.req, 0);
      chk("t4_busy", bus.busy, 0);
      chk("t4_level", bus.fifo_level, 0);
      step();
      chk("t4_proto_sticky", bus.proto_err, 1);

      // reset in the middle of a tenure with a second command queued
      bus.cmd_valid = 1'b1; bus.cmd_len = 4'd3;
      step();
      step();
      bus.cmd_valid = 1'b0; bus.gnt = 1'b1;
      step();
      step();
      chk("t6_idx1", bus.beat_idx, 1);
      chk("t6_level_pre", bus.fifo_level, 2);
      resetb = 1'b1; bus.gnt = 1'b0;
      step();
      resetb = 1'b0;
      chk("t6_req", bus.req, 0);
      chk("t6_beat", bus.beat, 0);
      chk("t6_end", bus.end_access, 0);
      chk("t6_level", bus.fifo_level, 0);
      chk("t6_proto", bus.proto_err, 0);
      chk("t6_ready", bus.cmd_ready, 1);
      chk("t6_busy", bus.busy, 0);

      // grant withheld indefinitely
      bus.cmd_valid = 1'b1; bus.cmd_len = 4'd1;
      step();
      bus.cmd_valid = 1'b0;
      step();
      chk("t5_req_rise", bus.req, 1);
`ifdef ARB_MASTER_TIMEOUT_EN
      for (int i = 1; i < TO_CYC; i++) begin
         step();
         chk("t5_req_wait", bus.req, 1);
         chk("t5_toerr_wait", bus.to_err, 0);
      end
      step();
      chk("t5_toerr_pulse", bus.to_err, 1);
      chk("t5_req_drop", bus.req, 0);
      chk("t5_level_pop", bus.fifo_level, 0);
      step();
      chk("t5_toerr_end", bus.to_err, 0);
      chk("t5_busy_end", bus.busy, 0);
`else
      for (int i = 0; i < 100; i++) begin
         step();
         chk("t5_req_hold", bus.req, 1);
         chk("t5_toerr_zero", bus.to_err, 0);
      end
`endif
      do_reset();

      // randomized traffic against a queue model and a registered-grant arbiter
      model_level = 0; exp_idx = 0; wait_n = 0; bursts = 0;
      for (int c = 0; c < 700; c++) begin
         chk("rnd_level", bus.fifo_level, model_level);
         chk("rnd_ready", bus.cmd_ready, (model_level < DEPTH));
         chk("rnd_proto", bus.proto_err, 0);
         chk("rnd_toerr", bus.to_err, 0);
         if (bus.beat) begin
            last = (exp_q.size() > 0) && (exp_idx == int'(exp_q[0]));
            chk("rnd_idx", bus.beat_idx, exp_idx);
            chk("rnd_end", bus.end_access, last);
            chk("rnd_req_xfer", bus.req, (model_level > 1));
            if (last) begin
               void'(exp_q.pop_front());
               exp_idx = 0;
               bursts++;
            end else begin
               exp_idx++;
            end
         end else begin
            chk("rnd_end_idle", bus.end_access, 0);
         end

         if (bus.gnt)
            nxt_gnt = bus.end_access ? (bus.req && ($urandom_range(0, 1) == 1)) : 1'b1;
         else if (bus.req)
            nxt_gnt = (wait_n >= 3) || ($urandom_range(0, 3) != 0);
         else
            nxt_gnt = 1'b0;
         wait_n = (bus.req && !bus.gnt && !nxt_gnt) ? wait_n + 1 : 0;

         pushv = (c < 550) && ($urandom_range(0, 1) == 1);
         len   = LEN_W'($urandom_range(0, 15));
         bus.cmd_valid = pushv;
         bus.cmd_len   = len;
         acc = pushv && (model_level < DEPTH);
         if (acc) exp_q.push_back(len);
         model_level = model_level + (acc ? 1 : 0) - (bus.end_access ? 1 : 0);

         step();
         bus.gnt = nxt_gnt;
      end
      bus.cmd_valid = 1'b0;
      chk("rnd_queue_empty", exp_q.size(), 0);
      chk("rnd_busy_end", bus.busy, 0);
      chk("rnd_bursts_seen", (bursts > 0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/arb_master_port.md
# arb_master_port

- Requester-side endpoint of the 3-master weighted round-robin bus arbitration protocol; one instance per master.
- Queues burst commands from local logic and drives `req` and `end_access`, which become this master's bits of `req_vec` and `end_access_vec`.
- Watches its own `gnt_vec` bit and strobes data beats for the length of each granted tenure.
- The arbiter returns its grant registered, one cycle after it samples `req`/`end_access`.

## Interface
- `LEN_W`, 4: width of burst-length field; burst = `cmd_len`+1 beats (1..2^LEN_W).
- `DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `TO_CYCLES`, 64: grant-wait limit; used only with the timeout feature.
- `clk` in 1: single clock, rising edge.
- `resetb` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_len` in LEN_W: beats−1 of the offered command.
- `gnt` in 1: this master's bit of the arbiter's `gnt_vec`.
- `req` out 1: bus request to the arbiter.
- `end_access` out 1: one-cycle release pulse, coincident with the last beat.
- `beat` out 1: data-beat strobe while owning the bus.
- `beat_idx` out LEN_W: index of the current beat, 0-based.
- `busy` out 1: FSM not IDLE, or FIFO non-empty.
- `fifo_level` out clog2(DEPTH)+1: number of queued commands, including the one in service.
- `proto_err` out 1: sticky; `gnt` dropped mid-tenure.
- `to_err` out 1: one-cycle pulse on grant-wait timeout; tied 0 without the macro.

## Operation
- **FIFO**
  - Push on accept. Pop on the last beat of a tenure, on timeout, or on protocol abort.
  - `cmd_ready` = !full, so no push occurs while full.
  - Simultaneous push and pop: level unchanged.
- **FSM states:** IDLE, REQ, XFER.
- **IDLE**
  - FIFO non-empty → REQ; head `cmd_len` latched into `len_q`.
- **REQ**
  - `req`=1.
  - `gnt`=1 → XFER, `beat_idx` cleared to 0.
- **XFER**
  - `beat`=1 every cycle; `beat_idx` increments from 0.
  - Last beat is `beat_idx`==`len_q`. In that cycle: `end_access`=1 and pop.
  - After the last beat: entry remaining after pop → REQ with next `len_q`; otherwise → IDLE.
  - `req` in XFER = 1 iff FIFO holds an entry behind the current one, so the arbiter sees the request in the `end_access` cycle and can re-grant without a gap.
  - `gnt`=0 before the last beat: set `proto_err`, drop `req`, pop, → IDLE.
- **Re-grant:** `gnt` may stay high continuously across a tenure boundary. In REQ, `gnt`=1 always means a new grant, because the arbiter registers its grant.
- **Weights exhausted:** the arbiter withholds `gnt`; the port stays in REQ until a grant arrives (or times out, with the macro).
- **Reset:** returns to IDLE and flushes the FIFO. All outputs read 0 (`cmd_ready`=1 after reset). Reset mid-tenure releases without `end_access`; the arbiter must be reset in the same cycle.

## Timing
- Command accepted in cycle A with FSM in IDLE and FIFO empty: `req`=1 in cycle A+2.
- Grant first seen in cycle G (REQ, `gnt`=1): beats occupy cycles G+1 .. G+1+`len_q`; `end_access` in the last of them.
- Back-to-back re-grant: last beat at L, `req`=1 at L. If the arbiter keeps `gnt`=1 at L+1, the first beat of the next burst is at L+2.
- Outputs are registered state decodes; no combinational path from `gnt` or `cmd_valid` to any output.

## Configuration
- `ARB_MASTER_TIMEOUT_EN` defined:
  - A wait counter (width clog2(TO_CYCLES)+1) clears on REQ entry and counts each REQ cycle with `gnt`=0.
  - At TO_CYCLES: `to_err` pulses 1 cycle, `req` drops, the head command is popped, FSM → IDLE, or → REQ if more entries remain.
- Not defined: counter logic absent, REQ waits indefinitely, `to_err`=0.

## Test plan
- Reset, then push `cmd_len`=3 at A=5 and hold `gnt`=1 from cycle 8 → `req` at 7; beats 9–12 with `beat_idx` 0..3; `end_access` at 12 only; `fifo_level` 1→0 at 13.
- Push lens 0 and 2, then grant continuously → second `req` stays high in the `end_access` cycle of burst 1; burst 2 beats begin 2 cycles after that `end_access`; no `req` gap.
- Fill FIFO with 4 commands, drive `cmd_valid`=1 a fifth time → `cmd_ready`=0, fifth command not accepted; first pop restores `cmd_ready`=1.
- Drop `gnt` at `beat_idx`=1 of a 4-beat burst → `proto_err`=1 (sticky), no `end_access`, FSM IDLE.
- With `ARB_MASTER_TIMEOUT_EN`, TO_CYCLES=8, `gnt` held 0 → `to_err` pulse 8 cycles after `req` rises, `req` low; without the macro `req` remains high for 100 cycles.
- Assert `resetb` mid-XFER → next cycle `req`, `beat`, `end_access`=0, `fifo_level`=0, `proto_err`=0.
